// File: rtl/fibo_pkg.sv
// Shared types and default sizes for the Fibonacci sequence generator family.
package fibo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fibo_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 6;

endpackage

// File: rtl/fibo_add_carry.sv
// Combinational WIDTH-bit adder with the carry out split off, so callers can
// detect that the next term no longer fits.
module fibo_add_carry #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fibo_seq_gen.sv
// Fibonacci term generator: programmable seeds and count, valid/ready output,
// early stop when the next term would overflow WIDTH bits.
module fibo_seq_gen
  import fibo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             out_ready,
  output logic [WIDTH-1:0] fibo_out,
  output logic             out_valid,
  output logic [CNT_W-1:0] term_idx,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  fibo_state_t      state;
  logic [WIDTH-1:0] a, b, sum;
  logic             b_ovf, carry;
  logic [CNT_W-1:0] cnt, idx;

  fibo_add_carry #(.WIDTH(WIDTH)) u_add (
    .a    (a),
    .b    (b),
    .sum  (sum),
    .carry(carry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      a        <= '0;
      b        <= '0;
      b_ovf    <= 1'b0;
      cnt      <= '0;
      idx      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            overflow <= 1'b0;
            if (num_terms != '0) begin
              a     <= seed0;
              b     <= seed1;
              b_ovf <= 1'b0;
              idx   <= '0;
              cnt   <= num_terms;
              state <= ST_RUN;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (out_ready) begin
            // count limit wins over a pending overflow on the final term
            if (idx == cnt - CNT_W'(1)) begin
              state <= ST_DONE;
            end else if (b_ovf) begin
              state    <= ST_DONE;
              overflow <= 1'b1;
            end else begin
              a     <= b;
              b     <= sum;
              b_ovf <= carry;
              idx   <= idx + CNT_W'(1);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // outputs decode only registered state: no out_ready -> out_valid path
  assign fibo_out  = a;
  assign term_idx  = idx;
  assign out_valid = (state == ST_RUN);
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_fibo_seq_gen.sv
// Directed self-checking bench for fibo_seq_gen at WIDTH=8, CNT_W=6.
module tb_fibo_seq_gen;

  localparam int WIDTH = 8;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] seed0 = '0, seed1 = '0;
  logic [CNT_W-1:0] num_terms = '0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] fibo_out;
  logic             out_valid;
  logic [CNT_W-1:0] term_idx;
  logic             busy, done, overflow;

  int checks = 0;
  int errors = 0;

  fibo_seq_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .seed0    (seed0),
    .seed1    (seed1),
    .num_terms(num_terms),
    .out_ready(out_ready),
    .fibo_out (fibo_out),
    .out_valid(out_valid),
    .term_idx (term_idx),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // advance one edge and settle; all sampling happens 1ns after posedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int s0, input int s1, input int n);
    seed0     = WIDTH'(s0);
    seed1     = WIDTH'(s1);
    num_terms = CNT_W'(n);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({fibo_out, out_valid, term_idx, busy, done, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got fibo=%0d valid=%0b idx=%0d busy=%0b done=%0b ovf=%0b exp all 0",
               fibo_out, out_valid, term_idx, busy, done, overflow);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int exp_t[10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    out_ready = 1'b1;
    do_start(0, 1, 10);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (out_valid !== 1'b1 || fibo_out !== WIDTH'(exp_t[k]) || term_idx !== CNT_W'(k) || busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_term%0d: got valid=%0b val=%0d idx=%0d busy=%0b exp valid=1 val=%0d idx=%0d busy=1",
                 k, out_valid, fibo_out, term_idx, busy, exp_t[k], k);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b1 || overflow !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got valid=%0b done=%0b ovf=%0b busy=%0b exp 0 1 0 0",
               out_valid, done, overflow, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%0b valid=%0b exp 0 0", done, out_valid);
    end
  endtask

  // n=20 runs into overflow after 233; n=14 ends on 233 normally
  task automatic run_14(input string name, input int n, input logic exp_ovf);
    int exp_t[14] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
    out_ready = 1'b1;
    do_start(0, 1, n);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL %s_ovf_clear_at_accept: got %0b exp 0", name, overflow);
    end
    for (int k = 0; k < 14; k++) begin
      checks++;
      if (out_valid !== 1'b1 || fibo_out !== WIDTH'(exp_t[k]) || term_idx !== CNT_W'(k)) begin
        errors++;
        $display("FAIL %s_term%0d: got valid=%0b val=%0d idx=%0d exp valid=1 val=%0d idx=%0d",
                 name, k, out_valid, fibo_out, term_idx, exp_t[k], k);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b1 || overflow !== exp_ovf) begin
      errors++;
      $display("FAIL %s_end: got valid=%0b done=%0b ovf=%0b exp valid=0 done=1 ovf=%0b",
               name, out_valid, done, overflow, exp_ovf);
    end
    tick();
    checks++;
    if (overflow !== exp_ovf || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_sticky: got ovf=%0b busy=%0b done=%0b exp ovf=%0b busy=0 done=0",
               name, overflow, busy, done, exp_ovf);
    end
  endtask

  task automatic test_overflow();
    run_14("overflow", 20, 1'b1);
  endtask

  task automatic test_overflow_precedence();
    run_14("precedence", 14, 1'b0);
  endtask

  task automatic test_backpressure();
    int exp_t[5] = '{5, 3, 8, 11, 19};
    int k = 0;
    logic seen_done = 1'b0;
    do_start(5, 3, 5);
    for (int c = 0; c < 40 && !seen_done; c++) begin
      out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      if (out_valid) begin
        checks++;
        if (k >= 5 || fibo_out !== WIDTH'(exp_t[k < 5 ? k : 4]) || term_idx !== CNT_W'(k)) begin
          errors++;
          $display("FAIL bp_cycle%0d: got val=%0d idx=%0d exp val=%0d idx=%0d",
                   c, fibo_out, term_idx, exp_t[k < 5 ? k : 4], k);
        end
        if (out_ready) k++;
      end
      if (done) seen_done = 1'b1;
      tick();
    end
    checks++;
    if (k !== 5 || !seen_done) begin
      errors++;
      $display("FAIL bp_count: got transfers=%0d done_seen=%0b exp 5 1", k, seen_done);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_zero_count();
    do_start(7, 9, 0);
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: got done=%0b valid=%0b busy=%0b exp 1 0 0", done, out_valid, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_after: got done=%0b valid=%0b exp 0 0", done, out_valid);
    end
  endtask

  task automatic test_reset_midrun();
    int exp_t[3] = '{2, 2, 4};
    out_ready = 1'b1;
    do_start(0, 1, 10);
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({fibo_out, out_valid, term_idx, busy, done, overflow} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: got fibo=%0d valid=%0b idx=%0d busy=%0b done=%0b ovf=%0b exp all 0",
               fibo_out, out_valid, term_idx, busy, done, overflow);
    end
    reset = 1'b0;
    tick();
    do_start(2, 2, 3);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || fibo_out !== WIDTH'(exp_t[k]) || term_idx !== CNT_W'(k)) begin
        errors++;
        $display("FAIL post_reset_term%0d: got valid=%0b val=%0d idx=%0d exp valid=1 val=%0d idx=%0d",
                 k, out_valid, fibo_out, term_idx, exp_t[k], k);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_done: got done=%0b valid=%0b exp 1 0", done, out_valid);
    end
    tick();
  endtask

  // start held high with new seeds during RUN and DONE must change nothing
  task automatic test_ignored_start();
    int exp_t[6] = '{1, 1, 2, 3, 5, 8};
    out_ready = 1'b1;
    do_start(1, 1, 6);
    for (int k = 0; k < 6; k++) begin
      start = 1'b1;
      seed0 = 8'd99;
      seed1 = 8'd77;
      num_terms = 6'd1;
      checks++;
      if (out_valid !== 1'b1 || fibo_out !== WIDTH'(exp_t[k]) || term_idx !== CNT_W'(k)) begin
        errors++;
        $display("FAIL ignstart_term%0d: got valid=%0b val=%0d idx=%0d exp valid=1 val=%0d idx=%0d",
                 k, out_valid, fibo_out, term_idx, exp_t[k], k);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ignstart_done: got done=%0b valid=%0b exp 1 0", done, out_valid);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignstart_in_done: got busy=%0b valid=%0b done=%0b exp 0 0 0", busy, out_valid, done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_overflow_precedence();
    test_backpressure();
    test_zero_count();
    test_reset_midrun();
    test_ignored_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fibo_seq_gen.md
# fibo_seq_gen

Parametrised Fibonacci sequence generator with programmable seeds, a programmable term count, and a valid/ready output stream. One `start` pulse launches a run. The block emits terms until the requested count is reached or the next term would overflow `WIDTH` bits. It replaces the fixed-width, free-running generator and feeds downstream consumers (display, FIFO, checker) through a standard handshake.

## Interface
- `WIDTH`, default 8: bit width of the sequence terms, minimum 2.
- `CNT_W`, default 6: bit width of the term count and term index.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high; clears all state on the next rising edge.
- `start` in 1: run request; sampled only in IDLE.
- `seed0` in `WIDTH`: first term, captured on an accepted start.
- `seed1` in `WIDTH`: second term, captured on an accepted start.
- `num_terms` in `CNT_W`: number of terms to emit, captured on an accepted start.
- `out_ready` in 1: consumer ready.
- `fibo_out` out `WIDTH`: current term.
- `out_valid` out 1: `fibo_out` is valid.
- `term_idx` out `CNT_W`: index of the current term, 0-based.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse at the end of a run.
- `overflow` out 1: sticky; the run ended early on overflow.

## Operation
- FSM states: IDLE, RUN, DONE; encoding comes from the package.
- Datapath registers:
  - `a`: current term, drives `fibo_out`.
  - `b`: next term.
  - `b_ovf`: 1 when `b` was produced with a carry out.
  - `cnt`: captured `num_terms`.
  - `idx`: drives `term_idx`.
- Adder: `{carry, sum} = a + b`, computed at `WIDTH+1` bits.
- IDLE, `start`=1, `num_terms`≠0:
  - Loads `a`=`seed0`, `b`=`seed1`, `b_ovf`=0, `idx`=0, `cnt`=`num_terms`.
  - Clears `overflow` and goes to RUN.
- IDLE, `start`=1, `num_terms`=0: goes to DONE with no output and clears `overflow`.
- RUN: `out_valid`=1, `fibo_out`=`a`. A handshake (transfer) occurs when `out_valid`&&`out_ready`. On a transfer:
  - If `idx`==`cnt`-1: go to DONE. This is the normal end.
  - Else if `b_ovf`=1: go to DONE and set `overflow`=1. The overflowed term is never emitted.
  - Else: `a`<=`b`, `b`<=`sum`, `b_ovf`<=`carry`, `idx`<=`idx`+1.
- RUN, no transfer: `a`, `b`, `idx` hold; `fibo_out` is stable under backpressure.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` in RUN or DONE is ignored; no queuing.
- `seed0`/`seed1`/`num_terms` changes after capture have no effect on the current run.
- Overflow precedence: the count limit is checked first. A run whose final term index coincides with a pending overflow ends normally with `overflow`=0.
- With `WIDTH`=4, seeds 0/1 and a large count, the block reproduces the classic 4-bit sequence 0,1,1,2,3,5,8,13, then stops with `overflow`.

## Timing
- Reset values:
  - `fibo_out`=0, `out_valid`=0, `term_idx`=0, `busy`=0, `done`=0, `overflow`=0.
  - State IDLE; `a`=`b`=0.
- Start latency: `start` sampled at edge N gives `out_valid`=1 from edge N+1 with `fibo_out`=`seed0`.
- Throughput: one term per cycle with `out_ready` held high.
- The last transfer at edge M gives `out_valid`=0 and `done`=1 in cycle M+1, and IDLE at M+2. The earliest next start is sampled at edge M+2.
- All outputs are registered or decoded only from registered state; there is no combinational path from `out_ready` to `out_valid`.
- `reset` mid-run: at the next edge, all outputs return to reset values; no `done` pulse.
- `reset` takes priority over `start` in the same cycle.

## Structure
- Package `fibo_pkg`:
  - FSM state typedef (IDLE/RUN/DONE).
  - Default `WIDTH`/`CNT_W` localparams.
- Sub-module `fibo_add_carry` (param `WIDTH`): combinational `a`+`b` with separate carry out. It is reusable by the older generators.
- Top-level `fibo_seq_gen`: FSM, datapath registers, handshake.

## Test plan
- Basic run: `WIDTH`=8, seeds 0/1, `num_terms`=10, `out_ready`=1.
  - Terms 0,1,1,2,3,5,8,13,21,34 on consecutive cycles.
  - `term_idx` 0..9, `done` pulse once, `overflow`=0.
- Overflow: `WIDTH`=8, seeds 0/1, `num_terms`=20.
  - 14 terms ending at 233 (idx 13), then DONE with `overflow`=1; 377 is never emitted.
- Backpressure: seeds 5/3, `num_terms`=5, `out_ready` toggling 1,0,0,1,…
  - Stream 5,3,8,11,19 with no loss or duplicates; `fibo_out` stable while `out_ready`=0.
- Zero count: `start` with `num_terms`=0.
  - `out_valid` never asserts; `done` pulses the cycle after start.
- Reset mid-run: assert `reset` after 4 transfers.
  - Next cycle all outputs are at reset values; a following start with seeds 2/2, count 3 gives 2,2,4.
- Ignored start / overflow clear: `start` pulses during RUN do not alter the stream. A new start after an overflow run clears `overflow` at the accept edge.
